// File: rtl/game_pkg.sv
// Shared game constants, spawner state encoding and the lane-select LFSR step.
package game_pkg;

    localparam logic [3:0]  PLAY_CODE = 4'b0010;
    localparam int unsigned NUM_LANES = 8;
    localparam int unsigned LANE_W    = 3;
    localparam int unsigned LOCK_W    = 28;
    localparam int unsigned WAIT_W    = 28;
    localparam int unsigned PULSE_W   = 20;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned LFSR_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        PICK  = 2'd2,
        PULSE = 2'd3
    } state_t;

    // Fibonacci x^16+x^14+x^13+x^11+1, shifting right with feedback into the MSB
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/lane_lock_timer.sv
// Per-lane lockout down-counter; the lane is busy while the count is nonzero.
module lane_lock_timer
    import game_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [LOCK_W-1:0] load_val,
    input  logic              clear,
    output logic              busy
);

    logic [LOCK_W-1:0] count_q;

    // clear has priority over load so an erase always frees the lane
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - LOCK_W'(1);
        end
    end

    assign busy = (count_q != '0);

endmodule

// File: rtl/tile_spawner.sv
// Picks a pseudo-random free lane at a level-dependent interval and drives the
// renderer's one-hot lane-start pulse while the game is in PLAY.
module tile_spawner
    import game_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES  = 400_000,
    parameter int unsigned INTERVAL_EASY = 50_000_000,
    parameter int unsigned INTERVAL_HARD = 25_000_000,
    parameter int unsigned LOCK_EASY     = 200_000_000,
    parameter int unsigned LOCK_HARD     = 100_000_000,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           status,
    input  logic                 level,
    input  logic [NUM_LANES-1:0] erase,
    output logic [NUM_LANES-1:0] v_enb,
    output logic                 spawn_skip,
    output logic [CNT_W-1:0]     tile_cnt
);

    state_t               state_q;
    logic [WAIT_W-1:0]    wait_q;
    logic [PULSE_W-1:0]   pulse_q;
    logic [LANE_W-1:0]    cand_q;
    logic [LANE_W-1:0]    lane_q;
    logic [LANE_W-1:0]    last_q;
    logic [LANE_W-1:0]    tries_q;
    logic [LFSR_W-1:0]    lfsr_q;
    logic [NUM_LANES-1:0] v_enb_q;
    logic                 skip_q;
    logic [CNT_W-1:0]     cnt_q;

    logic                 play;
    logic                 cand_ok;
    logic [WAIT_W-1:0]    wait_load;
    logic [LOCK_W-1:0]    lock_val;
    logic [NUM_LANES-1:0] lock_busy;
    logic [NUM_LANES-1:0] lock_load;
    logic [NUM_LANES-1:0] lock_clear;

    assign play      = (status == PLAY_CODE);
    assign cand_ok   = !lock_busy[cand_q] && (cand_q != last_q);
    assign wait_load = level ? WAIT_W'(INTERVAL_HARD - 1) : WAIT_W'(INTERVAL_EASY - 1);
    assign lock_val  = level ? LOCK_W'(LOCK_HARD) : LOCK_W'(LOCK_EASY);

    // Lock load on lane acceptance; erase frees a lane except the one pulsing now
    always_comb begin
        lock_load  = '0;
        lock_clear = erase;
        if (play && state_q == PICK && cand_ok) begin
            lock_load[cand_q] = 1'b1;
        end
        if (state_q == PULSE) begin
            lock_clear[lane_q] = 1'b0;
        end
        if (!play) begin
            lock_clear = '1;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lock
        lane_lock_timer u_lock (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (lock_load[i]),
            .load_val (lock_val),
            .clear    (lock_clear[i]),
            .busy     (lock_busy[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= '0;
            pulse_q <= '0;
            cand_q  <= '0;
            lane_q  <= '0;
            last_q  <= LANE_W'(7);
            tries_q <= '0;
            lfsr_q  <= LFSR_SEED;
            v_enb_q <= '0;
            skip_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
            skip_q <= 1'b0;
            if (!play) begin
                state_q <= IDLE;
                v_enb_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        wait_q  <= wait_load;
                        cnt_q   <= '0;
                        state_q <= WAIT;
                    end
                    WAIT: begin
                        if (wait_q == '0) begin
                            cand_q  <= lfsr_q[LANE_W-1:0];
                            tries_q <= '0;
                            state_q <= PICK;
                        end else begin
                            wait_q <= wait_q - WAIT_W'(1);
                        end
                    end
                    PICK: begin
                        if (cand_ok) begin
                            lane_q  <= cand_q;
                            last_q  <= cand_q;
                            v_enb_q <= NUM_LANES'(1) << cand_q;
                            pulse_q <= PULSE_W'(PULSE_CYCLES - 1);
                            if (cnt_q != '1) begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                            state_q <= PULSE;
                        end else if (tries_q == LANE_W'(7)) begin
                            skip_q  <= 1'b1;
                            wait_q  <= wait_load;
                            state_q <= WAIT;
                        end else begin
                            cand_q  <= cand_q + LANE_W'(1);
                            tries_q <= tries_q + LANE_W'(1);
                        end
                    end
                    PULSE: begin
                        if (pulse_q == '0) begin
                            v_enb_q <= '0;
                            wait_q  <= wait_load;
                            state_q <= WAIT;
                        end else begin
                            pulse_q <= pulse_q - PULSE_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign v_enb      = v_enb_q;
    assign spawn_skip = skip_q;
    assign tile_cnt   = cnt_q;

endmodule
